// File: rtl/smmha_package.sv
// Shared types for the SMMHA accumulate engine.
// Control/status bundles and FSM state encoding.
package smmha_package;

  localparam int unsigned CNT_WIDTH = 16;

  typedef struct packed {
    logic                 start;
    logic [CNT_WIDTH-1:0] len;
    logic [5:0]           shift;
    logic                 relu;
  } ctrl_engine_t;

  typedef struct packed {
    logic                 busy;
    logic                 done;
    logic [CNT_WIDTH-1:0] cnt;
  } flags_engine_t;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    OUTPUT
  } engine_state_t;

endpackage

// File: rtl/hwpe_stream_intf_stream.sv
// Valid/ready stream with data and byte strobes.
// Source drives valid/data/strb, sink drives ready.
interface hwpe_stream_intf_stream #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                    valid;
  logic                    ready;
  logic [DATA_WIDTH-1:0]   data;
  logic [DATA_WIDTH/8-1:0] strb;

  modport source (
    output valid, data, strb,
    input  ready
  );

  modport sink (
    input  valid, data, strb,
    output ready
  );
endinterface

// File: rtl/smmha_sat_shift.sv
// Arithmetic right shift, saturation and optional ReLU
// from the accumulator width down to the data width.
module smmha_sat_shift #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ACC_WIDTH  = 48
) (
  input  logic [ACC_WIDTH-1:0]  acc,
  input  logic [5:0]            shift,
  input  logic                  relu,
  output logic [DATA_WIDTH-1:0] res
);

  localparam logic signed [ACC_WIDTH-1:0] MAX =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] MIN = ~MAX;

  logic signed [ACC_WIDTH-1:0] shd;

  always_comb begin
    shd = '0;
    // shifts past the width collapse to pure sign fill
    if ({26'd0, shift} >= 32'(ACC_WIDTH))
      shd = {ACC_WIDTH{acc[ACC_WIDTH-1]}};
    else
      shd = $signed(acc) >>> shift;
  end

  always_comb begin
    res = shd[DATA_WIDTH-1:0];
    if (shd > MAX)
      res = MAX[DATA_WIDTH-1:0];
    else if (shd < MIN)
      res = MIN[DATA_WIDTH-1:0];
    if (relu && res[DATA_WIDTH-1])
      res = '0;
  end

endmodule

// File: rtl/smmha_accum_engine.sv
// Accumulates len signed words from a_i and emits one
// shifted/saturated result on d_o per start pulse.
module smmha_accum_engine
  import smmha_package::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ACC_WIDTH  = 48
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   enable_i,
  input  logic                   clear_i,
  hwpe_stream_intf_stream.sink   a_i,
  hwpe_stream_intf_stream.source d_o,
  input  ctrl_engine_t           ctrl_i,
  output flags_engine_t          flags_o
);

  localparam logic [CNT_WIDTH-1:0] ONE = 1;

  engine_state_t        state, state_nxt;
  logic [ACC_WIDTH-1:0] acc;
  logic [CNT_WIDTH-1:0] cnt, len;
  logic [5:0]           shift;
  logic                 relu, done;
  logic                 kill, hs, last, go;
  logic [DATA_WIDTH-1:0] res;

  assign kill = rst_i | clear_i;
  assign hs   = a_i.valid & a_i.ready;
  assign last = hs & (cnt == len - ONE);
  assign go   = ctrl_i.start & (ctrl_i.len != '0);

  always_ff @(posedge clk_i) begin
    if (kill) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (go)        state_nxt = ACCUM;
      ACCUM:   if (last)      state_nxt = OUTPUT;
      OUTPUT:  if (d_o.ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (kill) begin
      acc   <= '0;
      cnt   <= '0;
      len   <= '0;
      shift <= '0;
      relu  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE && ctrl_i.start) begin
        if (go) begin
          len   <= ctrl_i.len;
          shift <= ctrl_i.shift;
          relu  <= ctrl_i.relu;
          acc   <= '0;
          cnt   <= '0;
        end else begin
          done <= 1'b1;
        end
      end else if (state == ACCUM && hs) begin
        acc <= acc + {{(ACC_WIDTH-DATA_WIDTH){a_i.data[DATA_WIDTH-1]}}, a_i.data};
        cnt <= cnt + ONE;
      end else if (state == OUTPUT && d_o.ready) begin
        done <= 1'b1;
      end
    end
  end

  smmha_sat_shift #(
    .DATA_WIDTH (DATA_WIDTH),
    .ACC_WIDTH  (ACC_WIDTH)
  ) u_sat (
    .acc   (acc),
    .shift (shift),
    .relu  (relu),
    .res   (res)
  );

  assign a_i.ready    = (state == ACCUM) & enable_i;
  assign d_o.valid    = (state == OUTPUT);
  assign d_o.data     = (state == OUTPUT) ? res : '0;
  assign d_o.strb     = '1;
  assign flags_o.busy = (state != IDLE);
  assign flags_o.done = done;
  assign flags_o.cnt  = cnt;

endmodule

// File: tb/tb_smmha_accum_engine.sv
// Directed and randomized jobs for the accumulate engine,
// checked against an arithmetic reference model.
module tb_smmha_accum_engine;
  import smmha_package::*;

  logic          clk = 1'b0;
  logic          rst, enable, clear;
  ctrl_engine_t  ctrl;
  flags_engine_t flags;
  int            total = 0;
  int            bad   = 0;
  int            words[$];

  hwpe_stream_intf_stream #(.DATA_WIDTH(32)) a_s ();
  hwpe_stream_intf_stream #(.DATA_WIDTH(32)) d_s ();

  always #5 clk = ~clk;

  smmha_accum_engine #(
    .DATA_WIDTH (32),
    .ACC_WIDTH  (48)
  ) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .enable_i (enable),
    .clear_i  (clear),
    .a_i      (a_s),
    .d_o      (d_s),
    .ctrl_i   (ctrl),
    .flags_o  (flags)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model(input int n, input int sh,
                                        input bit rl);
    longint sum = 0;
    longint r;
    for (int i = 0; i < n; i++) sum += longint'(words[i]);
    r = sum >>> sh;
    if (r > 64'sd2147483647)  r = 64'sd2147483647;
    if (r < -64'sd2147483648) r = -64'sd2147483648;
    if (rl && r < 0) r = 0;
    return r[31:0];
  endfunction

  task automatic do_job(input int n, input int sh, input bit rl,
                        input int hold, input bit rnd, input bit restart);
    logic [31:0] exp;
    int          i = 0;
    int          budget = 0;
    exp = model(n, sh, rl);
    @(negedge clk);
    ctrl.start = 1'b1;
    ctrl.len   = 16'(n);
    ctrl.shift = 6'(sh);
    ctrl.relu  = rl;
    @(negedge clk);
    ctrl.start = 1'b0;
    chk("busy_after_start", 64'(flags.busy), 64'd1);
    while (i < n) begin
      enable     = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      ctrl.start = restart && (i == 1);
      ctrl.len   = restart ? 16'd1 : 16'(n);
      a_s.valid  = 1'b1;
      a_s.data   = words[i];
      #1;
      if (a_s.ready) i++;
      @(negedge clk);
      budget++;
      if (budget > 200) begin
        chk("accum_timeout", 64'(i), 64'(n));
        break;
      end
    end
    ctrl.start = 1'b0;
    a_s.valid  = 1'b0;
    enable     = 1'b1;
    chk("out_valid", 64'(d_s.valid), 64'd1);
    chk("out_data", 64'(d_s.data), 64'(exp));
    chk("in_ready_low", 64'(a_s.ready), 64'd0);
    chk("cnt_final", 64'(flags.cnt), 64'(n));
    for (int k = 0; k < hold; k++) begin
      enable = ~enable;
      @(negedge clk);
      chk("hold_valid", 64'(d_s.valid), 64'd1);
      chk("hold_data", 64'(d_s.data), 64'(exp));
      chk("hold_in_ready", 64'(a_s.ready), 64'd0);
    end
    enable    = 1'b1;
    d_s.ready = 1'b1;
    @(negedge clk);
    d_s.ready = 1'b0;
    chk("done_pulse", 64'(flags.done), 64'd1);
    chk("valid_dropped", 64'(d_s.valid), 64'd0);
    chk("busy_idle", 64'(flags.busy), 64'd0);
    @(negedge clk);
    chk("done_one_cycle", 64'(flags.done), 64'd0);
    chk("cnt_holds", 64'(flags.cnt), 64'(n));
  endtask

  initial begin
    rst        = 1'b1;
    clear      = 1'b0;
    enable     = 1'b1;
    ctrl       = '0;
    a_s.valid  = 1'b0;
    a_s.data   = '0;
    a_s.strb   = '1;
    d_s.ready  = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(flags.busy), 64'd0);
    chk("rst_done", 64'(flags.done), 64'd0);
    chk("rst_cnt", 64'(flags.cnt), 64'd0);
    chk("rst_dvalid", 64'(d_s.valid), 64'd0);
    chk("rst_ddata", 64'(d_s.data), 64'd0);
    chk("rst_strb", 64'(d_s.strb), 64'hF);
    chk("rst_aready", 64'(a_s.ready), 64'd0);
    rst = 1'b0;

    words = '{1, 2, 3, 4};
    do_job(4, 0, 1'b0, 0, 1'b0, 1'b0);
    words = '{32'h7FFFFFFF, 32'h7FFFFFFF};
    do_job(2, 0, 1'b0, 0, 1'b0, 1'b0);
    words = '{32'h80000000, 32'h80000000};
    do_job(2, 0, 1'b0, 0, 1'b0, 1'b0);
    words = '{-5, -7};
    do_job(2, 0, 1'b1, 0, 1'b0, 1'b0);
    words = '{-8, -8, -9};
    do_job(3, 2, 1'b0, 0, 1'b0, 1'b0);
    words = '{1, 2, 3, 4};
    do_job(4, 0, 1'b0, 5, 1'b0, 1'b0);

    // abort after three accepted words
    @(negedge clk);
    ctrl.start = 1'b1;
    ctrl.len   = 16'd8;
    ctrl.shift = '0;
    ctrl.relu  = 1'b0;
    @(negedge clk);
    ctrl.start = 1'b0;
    a_s.valid  = 1'b1;
    a_s.data   = 32'd100;
    repeat (3) @(negedge clk);
    chk("abort_cnt", 64'(flags.cnt), 64'd3);
    clear = 1'b1;
    @(negedge clk);
    clear     = 1'b0;
    a_s.valid = 1'b0;
    chk("abort_busy", 64'(flags.busy), 64'd0);
    chk("abort_aready", 64'(a_s.ready), 64'd0);
    chk("abort_dvalid", 64'(d_s.valid), 64'd0);
    @(negedge clk);
    chk("abort_no_word", 64'(d_s.valid), 64'd0);
    words = '{5};
    do_job(1, 0, 1'b0, 0, 1'b0, 1'b0);

    // zero-length job
    @(negedge clk);
    ctrl.start = 1'b1;
    ctrl.len   = 16'd0;
    @(negedge clk);
    ctrl.start = 1'b0;
    chk("len0_done", 64'(flags.done), 64'd1);
    chk("len0_busy", 64'(flags.busy), 64'd0);
    @(negedge clk);
    chk("len0_done_end", 64'(flags.done), 64'd0);
    chk("len0_no_word", 64'(d_s.valid), 64'd0);

    words = '{10, 20, 30, 40};
    do_job(4, 1, 1'b0, 0, 1'b0, 1'b1);

    for (int j = 0; j < 12; j++) begin
      int n, sh;
      n  = $urandom_range(1, 6);
      sh = (j % 4 == 3) ? $urandom_range(48, 63) : $urandom_range(0, 40);
      words = {};
      for (int k = 0; k < n; k++) begin
        int w;
        w = int'($urandom);
        if (j % 3 == 0) w = w >>> 16;
        words.push_back(w);
      end
      do_job(n, sh, 1'($urandom_range(0, 1)), $urandom_range(0, 3),
             1'b1, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
